// File: rtl/filter_load_sequencer.sv
// Filter load sequencer: moves NUM_CH-bank filter sets from a FWFT FIFO into scratchpad banks.
// Optional macro FLR_STALL_COUNT_EN adds a 16-bit stall_cycles counter output.
module filter_load_sequencer #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 4,
   parameter int FCNT_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] filt_len,
   input  logic [FCNT_W-1:0] num_filt,
   input  logic              fifo_empty,
   output logic              fifo_ren,
   output logic              sp_wen,
   output logic [NUM_CH-1:0] sp_bank,
   output logic [ADDR_W-1:0] sp_addr,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic              err
`ifdef FLR_STALL_COUNT_EN
   , output logic [15:0]     stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] word_cnt;
   logic [FCNT_W-1:0] filt_idx;
   logic [ADDR_W-1:0] len_q;
   logic [FCNT_W-1:0] num_q;
   logic              rej_q;

   logic cfg_bad;
   logic write_en;
   logic last_word;
   logic last_filt;

   // A zero-sized job or one naming more filters than there are banks is rejected outright.
   assign cfg_bad   = (filt_len == '0) || (num_filt == '0) || (32'(num_filt) > NUM_CH);
   assign write_en  = (state == ST_LOAD) && !fifo_empty && !abort;
   assign last_word = (word_cnt == len_q - ADDR_W'(1));
   assign last_filt = (filt_idx == num_q - FCNT_W'(1));

   assign fifo_ren = write_en;
   assign sp_wen   = write_en;
   assign sp_bank  = write_en ? (NUM_CH'(1) << filt_idx) : '0;
   assign sp_addr  = word_cnt;
   assign busy     = (state == ST_LOAD) || (state == ST_WAIT);
   assign stall    = (state == ST_WAIT);
   assign done     = (state == ST_DONE);
   assign err      = (state == ST_DONE) && rej_q;

   // Abort out of any active state wins over everything except reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         word_cnt <= '0;
         filt_idx <= '0;
         len_q    <= '0;
         num_q    <= '0;
         rej_q    <= 1'b0;
      end else if (abort && (state != ST_IDLE)) begin
         state    <= ST_IDLE;
         word_cnt <= '0;
         filt_idx <= '0;
         rej_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  word_cnt <= '0;
                  filt_idx <= '0;
                  if (cfg_bad) begin
                     state <= ST_DONE;
                     rej_q <= 1'b1;
                  end else begin
                     state <= ST_LOAD;
                     len_q <= filt_len;
                     num_q <= num_filt;
                     rej_q <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (fifo_empty) begin
                  state <= ST_WAIT;
               end else if (last_word) begin
                  word_cnt <= '0;
                  if (last_filt) begin
                     filt_idx <= '0;
                     state    <= ST_DONE;
                  end else begin
                     filt_idx <= filt_idx + FCNT_W'(1);
                  end
               end else begin
                  word_cnt <= word_cnt + ADDR_W'(1);
               end
            end
            ST_WAIT: begin
               if (!fifo_empty) begin
                  state <= ST_LOAD;
               end
            end
            default: begin
               state <= ST_IDLE;
               rej_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FLR_STALL_COUNT_EN
   // Counts starved cycles of the current job and holds the total after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (abort && (state != ST_IDLE)) begin
         stall_cycles <= '0;
      end else if ((state == ST_IDLE) && start && !abort) begin
         stall_cycles <= '0;
      end else if ((state == ST_WAIT) && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_filter_load_sequencer.sv
// Self-checking bench for filter_load_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based job model.
module tb_filter_load_sequencer;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 4;
   localparam int FCNT_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              fifo_empty = 1'b1;
   logic [ADDR_W-1:0] filt_len = '0;
   logic [FCNT_W-1:0] num_filt = '0;
   logic              fifo_ren, sp_wen, busy, stall, done, err;
   logic [NUM_CH-1:0] sp_bank;
   logic [ADDR_W-1:0] sp_addr;
`ifdef FLR_STALL_COUNT_EN
   logic [15:0]       stall_cycles;
`endif

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   filter_load_sequencer #(
      .NUM_CH(NUM_CH),
      .ADDR_W(ADDR_W),
      .FCNT_W(FCNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .filt_len(filt_len),
      .num_filt(num_filt),
      .fifo_empty(fifo_empty),
      .fifo_ren(fifo_ren),
      .sp_wen(sp_wen),
      .sp_bank(sp_bank),
      .sp_addr(sp_addr),
      .busy(busy),
      .stall(stall),
      .done(done),
      .err(err)
`ifdef FLR_STALL_COUNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit s, input int len, input int nf, input bit fe, input bit ab);
      @(posedge clk);
      #1;
      start      = s;
      filt_len   = ADDR_W'(len);
      num_filt   = FCNT_W'(nf);
      fifo_empty = fe;
      abort      = ab;
   endtask

   // Job model: phase 0 idle, 1 running, 2 finished; the remaining writes sit in queues.
   int mPhase = 0;
   bit mStalled = 1'b0;
   bit mErr = 1'b0;
   int mStallCnt = 0;
   int expAddr[$];
   int expBank[$];

   always @(negedge clk) begin
      int eWen;
      int eBank;
      if (rst) begin
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_sp_wen", sp_wen, 0);
         checkOutput("rst_fifo_ren", fifo_ren, 0);
         checkOutput("rst_sp_bank", sp_bank, 0);
         checkOutput("rst_sp_addr", sp_addr, 0);
         checkOutput("rst_done", done, 0);
         checkOutput("rst_err", err, 0);
`ifdef FLR_STALL_COUNT_EN
         checkOutput("rst_stall_cycles", stall_cycles, 0);
`endif
         mPhase = 0;
         mStalled = 1'b0;
         mErr = 1'b0;
         mStallCnt = 0;
         expAddr.delete();
         expBank.delete();
      end else begin
         eWen  = (mPhase == 1 && !mStalled && !fifo_empty && !abort) ? 1 : 0;
         eBank = (eWen == 1) ? expBank[0] : 0;
         checkOutput("busy", busy, (mPhase == 1) ? 1 : 0);
         checkOutput("stall", stall, (mPhase == 1 && mStalled) ? 1 : 0);
         checkOutput("done", done, (mPhase == 2) ? 1 : 0);
         checkOutput("err", err, (mPhase == 2 && mErr) ? 1 : 0);
         checkOutput("fifo_ren", fifo_ren, eWen);
         checkOutput("sp_wen", sp_wen, eWen);
         checkOutput("sp_bank", sp_bank, eBank);
         if (eWen == 1) checkOutput("sp_addr", sp_addr, expAddr[0]);
`ifdef FLR_STALL_COUNT_EN
         checkOutput("stall_cycles", stall_cycles, mStallCnt);
`endif
         case (mPhase)
            0: begin
               if (start && !abort) begin
                  mStallCnt = 0;
                  if (filt_len == 0 || num_filt == 0 || num_filt > NUM_CH) begin
                     mPhase = 2;
                     mErr = 1'b1;
                  end else begin
                     for (int f = 0; f < int'(num_filt); f++)
                        for (int w = 0; w < int'(filt_len); w++) begin
                           expAddr.push_back(w);
                           expBank.push_back(1 << f);
                        end
                     mPhase = 1;
                     mStalled = 1'b0;
                     mErr = 1'b0;
                  end
               end
            end
            1: begin
               if (abort) begin
                  mPhase = 0;
                  mStallCnt = 0;
                  expAddr.delete();
                  expBank.delete();
               end else if (mStalled) begin
                  if (mStallCnt < 65535) mStallCnt++;
                  if (!fifo_empty) mStalled = 1'b0;
               end else if (fifo_empty) begin
                  mStalled = 1'b1;
               end else begin
                  void'(expAddr.pop_front());
                  void'(expBank.pop_front());
                  if (expAddr.size() == 0) begin
                     mPhase = 2;
                     mErr = 1'b0;
                  end
               end
            end
            default: begin
               if (abort) mStallCnt = 0;
               mPhase = 0;
            end
         endcase
      end
   end

   initial begin
      int litAddr[6] = '{0, 1, 2, 0, 1, 2};
      int litBank[6] = '{1, 1, 1, 2, 2, 2};
      int badLen[3]  = '{2, 0, 2};
      int badNum[3]  = '{0, 2, 5};
      int nWen, nStall, nDone, lastAddr;

      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      // 3-word x 2-filter job with a never-empty FIFO.
      applyStimulus(1, 3, 2, 0, 0);
      applyStimulus(0, 3, 2, 0, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("lit_wen", sp_wen, 1);
         checkOutput("lit_addr", sp_addr, litAddr[i]);
         checkOutput("lit_bank", sp_bank, litBank[i]);
      end
      @(negedge clk);
      checkOutput("lit_done_6", done, 1);
      checkOutput("lit_err_6", err, 0);

      // 2-word job starved for three cycles after the first word.
      applyStimulus(1, 2, 1, 0, 0);
      nWen = 0; nStall = 0; nDone = 0; lastAddr = -1;
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(0, 2, 1, (c >= 2 && c <= 4), 0);
         @(negedge clk);
         if (sp_wen) begin nWen++; lastAddr = int'(sp_addr); end
         if (stall) nStall++;
         if (done) nDone++;
      end
      checkOutput("lit_stall_len", nStall, 3);
      checkOutput("lit_stall_writes", nWen, 2);
      checkOutput("lit_stall_second_addr", lastAddr, 1);
      checkOutput("lit_stall_done_once", nDone, 1);
`ifdef FLR_STALL_COUNT_EN
      checkOutput("lit_stall_cycles", stall_cycles, 3);
`endif

      // Rejected configurations.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, badLen[k], badNum[k], 0, 0);
         applyStimulus(0, badLen[k], badNum[k], 0, 0);
         @(negedge clk);
         checkOutput("lit_rej_done", done, 1);
         checkOutput("lit_rej_err", err, 1);
         checkOutput("lit_rej_ren", fifo_ren, 0);
         applyStimulus(0, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput("lit_rej_done_clear", done, 0);
      end

      // Abort in the second filter of a 4x4 job, then a 1x1 job.
      applyStimulus(1, 4, 4, 0, 0);
      for (int c = 1; c <= 6; c++) applyStimulus(0, 4, 4, 0, 0);
      applyStimulus(0, 4, 4, 0, 1);
      @(negedge clk);
      checkOutput("lit_abort_no_write", sp_wen, 0);
      applyStimulus(0, 4, 4, 0, 0);
      @(negedge clk);
      checkOutput("lit_abort_idle", busy, 0);
      checkOutput("lit_abort_no_done", done, 0);
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("lit_1x1_wen", sp_wen, 1);
      checkOutput("lit_1x1_addr", sp_addr, 0);
      checkOutput("lit_1x1_bank", sp_bank, 1);
      applyStimulus(0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("lit_1x1_done", done, 1);

      // Asynchronous reset in the middle of a load.
      applyStimulus(1, 4, 2, 0, 0);
      applyStimulus(0, 4, 2, 0, 0);
      applyStimulus(0, 4, 2, 0, 0);
      #1 checkOutput("lit_pre_rst_wen", sp_wen, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("lit_async_wen", sp_wen, 0);
      checkOutput("lit_async_ren", fifo_ren, 0);
      checkOutput("lit_async_busy", busy, 0);
      checkOutput("lit_async_bank", sp_bank, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 0);
      nDone = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) nDone++;
         applyStimulus(0, 1, 1, 0, 0);
      end
      checkOutput("lit_post_rst_one_job", nDone, 1);

      // Randomized traffic against the model.
      repeat (3000) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 7),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      end
      repeat (80) applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
